// File: rtl/qam16_hard_slicer_if.sv
// Sample-side and FIFO-side signals of the 16-QAM hard slicer.
// master drives samples and FIFO gating; slave is the slicer itself.
interface qam16_hard_slicer_if #(
  parameter int SAMPLE_W = 12,
  parameter int DROP_W   = 16
);
  logic                       enable;
  logic                       sym_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [SAMPLE_W-1:0] q_sample;
  logic                       write_enable;
  logic                       wfull;
  logic [7:0]                 fifo_wdata;
  logic                       fifo_wreq;
  logic                       half_pending;
  logic [DROP_W-1:0]          drop_count;
  logic                       pack_state;

  modport master (
    output enable, sym_valid, i_sample, q_sample, write_enable, wfull,
    input  fifo_wdata, fifo_wreq, half_pending, drop_count, pack_state
  );

  modport slave (
    input  enable, sym_valid, i_sample, q_sample, write_enable, wfull,
    output fifo_wdata, fifo_wreq, half_pending, drop_count, pack_state
  );
endinterface

// File: rtl/qam16_hard_slicer.sv
// Hard-decision 16-QAM slicer: three-stage pipeline (register, slice, pack)
// turning I/Q samples into Gray nibbles packed two per FIFO byte.
module qam16_hard_slicer #(
  parameter int SAMPLE_W = 12,
  parameter int THRESH   = 512,
  parameter int DROP_W   = 16
) (
  input logic                dclk,
  input logic                reset,
  qam16_hard_slicer_if.slave bus
);

  // Handshake: sym_valid is a one-cycle qualifier with no ready (no upstream
  // backpressure); a formed byte is written only when write_enable=1 and
  // wfull=0 at the forming edge, otherwise it is dropped and counted.

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pack_state_e;

  localparam logic signed [SAMPLE_W-1:0] T_POS = SAMPLE_W'(THRESH);
  localparam logic signed [SAMPLE_W-1:0] T_NEG = SAMPLE_W'(-THRESH);

  logic                       a_valid_q;
  logic signed [SAMPLE_W-1:0] a_i_q;
  logic signed [SAMPLE_W-1:0] a_q_q;

  logic                       b_valid_q;
  logic [3:0]                 b_nib_q;
  logic [3:0]                 slice_nib;

  pack_state_e                state_q, state_d;
  logic [3:0]                 hold_q, hold_d;
  logic [7:0]                 wdata_q, wdata_d;
  logic                       wreq_q, wreq_d;
  logic [DROP_W-1:0]          drop_q, drop_d;

  // Signed window compares keep the most-negative sample legal (no abs()).
  function automatic logic [1:0] slice_axis(input logic signed [SAMPLE_W-1:0] x);
    logic sgn;
    logic mag;
    sgn = ~x[SAMPLE_W-1];
    mag = (x > T_NEG) && (x < T_POS);
    return {sgn, mag};
  endfunction

  assign slice_nib = {slice_axis(a_i_q), slice_axis(a_q_q)};

  always_ff @(posedge dclk) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_i_q     <= '0;
      a_q_q     <= '0;
    end else if (!bus.enable) begin
      a_valid_q <= 1'b0;
    end else begin
      a_valid_q <= bus.sym_valid;
      if (bus.sym_valid) begin
        a_i_q <= bus.i_sample;
        a_q_q <= bus.q_sample;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      b_valid_q <= 1'b0;
      b_nib_q   <= 4'h0;
    end else if (!bus.enable) begin
      b_valid_q <= 1'b0;
    end else begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_nib_q <= slice_nib;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      hold_q  <= 4'h0;
      wdata_q <= 8'h00;
      wreq_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wdata_q <= wdata_d;
      wreq_q  <= wreq_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    wdata_d = wdata_q;
    wreq_d  = 1'b0;
    drop_d  = drop_q;
    if (!bus.enable) begin
      // Flush: a byte forming this cycle is neither written nor counted.
      state_d = ST_EMPTY;
    end else if (b_valid_q) begin
      case (state_q)
        ST_EMPTY: begin
          hold_d  = b_nib_q;
          state_d = ST_HALF;
        end
        ST_HALF: begin
          state_d = ST_EMPTY;
          if (bus.write_enable && !bus.wfull) begin
            wreq_d  = 1'b1;
            wdata_d = {hold_q, b_nib_q};
          end else if (drop_q != {DROP_W{1'b1}}) begin
            drop_d = drop_q + 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign bus.fifo_wdata   = wdata_q;
  assign bus.fifo_wreq    = wreq_q;
  assign bus.half_pending = (state_q == ST_HALF);
  assign bus.drop_count   = drop_q;
  assign bus.pack_state   = state_q;

endmodule
